// File: rtl/uart_cmd_wrapper.sv
// Byte-side wrapper for a UART: packs three received bytes (MSB first) into a
// 24-bit command and sends single-byte responses back through the transmitter.
module uart_cmd_wrapper #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int GW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  rx_state_t     rx_state;
  tx_state_t     tx_state;
  logic [7:0]    hold_hi;
  logic [7:0]    hold_mid;
  logic [GW-1:0] gap;
  logic          tx_done_q;
  logic          consume;

  // Requiring clr_rdy low keeps a byte from being taken twice while rdy falls.
  assign consume = rdy & ~clr_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= BYTE0;
      hold_hi  <= '0;
      hold_mid <= '0;
      gap      <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      clr_rdy  <= 1'b0;
    end else begin
      clr_rdy <= consume;
      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      if (consume) begin
        gap <= '0;
        case (rx_state)
          BYTE0: begin
            hold_hi  <= rx_data;
            cmd_rdy  <= 1'b0;
            rx_state <= BYTE1;
          end
          BYTE1: begin
            hold_mid <= rx_data;
            rx_state <= BYTE2;
          end
          BYTE2: begin
            cmd      <= {hold_hi, hold_mid, rx_data};
            cmd_rdy  <= 1'b1;
            rx_state <= BYTE0;
          end
          default: rx_state <= BYTE0;
        endcase
      end else if (rx_state != BYTE0) begin
        // A stalled partial command is dropped so the next byte starts afresh.
        if (gap == GAP_MAX) begin
          gap      <= '0;
          rx_state <= BYTE0;
        end else begin
          gap <= gap + GW'(1);
        end
      end else begin
        gap <= '0;
      end
    end
  end

  // Completion is the 0->1 edge of tx_done, so a level left high by the
  // previous frame cannot end the wait early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data  <= resp;
            trmt     <= 1'b1;
            tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_done && !tx_done_q) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: UART byte-side models drive rx/tx,
// a reference model predicts commands and responses, a monitor checks them.
module tb_uart_cmd_wrapper;

  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rdy;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  typedef struct {
    logic [23:0] value;
    int          at_cyc;
  } cmd_exp_t;

  typedef struct {
    logic [7:0] value;
    int         at_cyc;
  } tx_exp_t;

  cmd_exp_t   cmdQ[$];
  tx_exp_t    trmtQ[$];
  logic [7:0] pending[$];

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         lastConsume = 0;
  int         bytesSent = 0;
  int         clrCount = 0;
  int         riseCyc = -10;
  bit         riseValid = 1'b0;
  bit         txBusy = 1'b0;
  logic [7:0] frameByte = 8'h00;
  bit         prevCmdRdy = 1'b0;
  bit         prevClr = 1'b0;
  bit         prevTrmt = 1'b0;
  bit         prevSent = 1'b0;
  cmd_exp_t   monCmd;
  tx_exp_t    monTx;

  uart_cmd_wrapper #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .rx_data    (rx_data),
    .clr_rdy    (clr_rdy),
    .tx_done    (tx_done),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;

  // Posedge counter: after "@(posedge clk); #1" it equals the index of that edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bytes gather into a command; a gap of more than TIMEOUT edges
  // between consumes throws away whatever partial command was collected.
  function automatic void modelConsume(input logic [7:0] b, input int e);
    cmd_exp_t c;
    if (pending.size() > 0 && (e - lastConsume) > TIMEOUT)
      pending.delete();
    pending.push_back(b);
    if (pending.size() == 3) begin
      c.value  = {pending[0], pending[1], pending[2]};
      c.at_cyc = e;
      cmdQ.push_back(c);
      pending.delete();
    end
    lastConsume = e;
  endfunction

  // Present one received byte so it is consumed 'delta' edges after the last one.
  task automatic applyStimulus(input logic [7:0] b, input int delta, input bit clrWith);
    int target;
    target = lastConsume + delta;
    while (cyc < target - 1) begin
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clrWith;
    @(posedge clk); #1;
    checkOutput("clr_rdy_after_consume", {31'd0, clr_rdy}, 32'd1);
    modelConsume(b, cyc);
    bytesSent++;
    rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic waitTxIdle();
    int n;
    n = 0;
    while (txBusy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("tx_idle_in_time", {31'd0, txBusy}, 32'd0);
  endtask

  task automatic sendResp(input logic [7:0] b, input int hold, input bit extra);
    tx_exp_t t;
    waitTxIdle();
    if (!txBusy) begin
      txBusy = 1'b1;
      send_resp = 1'b1;
      resp = b;
      t.value  = b;
      t.at_cyc = cyc + 1;
      trmtQ.push_back(t);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      send_resp = 1'b0;
      resp = 8'($urandom);
      if (extra) begin
        repeat (2) begin
          @(posedge clk); #1;
        end
        send_resp = 1'b1;
        resp = ~b;
        @(posedge clk); #1;
        send_resp = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("reset_clr_rdy", {31'd0, clr_rdy}, 32'd0);
    checkOutput("reset_trmt", {31'd0, trmt}, 32'd0);
    checkOutput("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("reset_resp_sent", {31'd0, resp_sent}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_cmd", {8'd0, cmd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pending.delete();
    lastConsume = cyc;
  endtask

  // UART transmitter: tx_done drops after trmt and rises after a random frame time.
  initial begin
    forever begin
      @(negedge clk);
      if (trmt && rst_n) begin
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat ($urandom_range(20, 60)) @(posedge clk);
        #1;
        tx_done = 1'b1;
        riseCyc = cyc;
        riseValid = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevCmdRdy = 1'b0;
        prevClr = 1'b0;
        prevTrmt = 1'b0;
        prevSent = 1'b0;
      end else begin
        if (clr_rdy) begin
          clrCount++;
          checkOutput("clr_rdy_single_cycle", {31'd0, prevClr}, 32'd0);
        end
        if (cmd_rdy && !prevCmdRdy) begin
          checkOutput("cmd_expected", {31'd0, cmdQ.size() > 0}, 32'd1);
          if (cmdQ.size() > 0) begin
            monCmd = cmdQ.pop_front();
            checkOutput("cmd_value", {8'd0, cmd}, {8'd0, monCmd.value});
            checkOutput("cmd_rdy_latency", cyc, monCmd.at_cyc);
          end
        end
        if (trmt) begin
          checkOutput("trmt_single_cycle", {31'd0, prevTrmt}, 32'd0);
          checkOutput("trmt_expected", {31'd0, trmtQ.size() > 0}, 32'd1);
          if (trmtQ.size() > 0) begin
            monTx = trmtQ.pop_front();
            checkOutput("tx_data_at_trmt", {24'd0, tx_data}, {24'd0, monTx.value});
            checkOutput("trmt_latency", cyc, monTx.at_cyc);
            frameByte = monTx.value;
          end
        end
        if (resp_sent) begin
          checkOutput("resp_sent_single_cycle", {31'd0, prevSent}, 32'd0);
          checkOutput("resp_sent_expected", {31'd0, riseValid}, 32'd1);
          checkOutput("resp_sent_latency", cyc, riseCyc + 1);
          checkOutput("tx_data_stable", {24'd0, tx_data}, {24'd0, frameByte});
          riseValid = 1'b0;
          txBusy = 1'b0;
        end
        prevCmdRdy = cmd_rdy;
        prevClr = clr_rdy;
        prevTrmt = trmt;
        prevSent = resp_sent;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Basic command, held without acknowledge
    applyStimulus(8'hA5, 3, 1'b0);
    applyStimulus(8'h12, 3, 1'b0);
    applyStimulus(8'h34, 3, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("cmd_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    checkOutput("cmd_A51234", {8'd0, cmd}, 32'h00A51234);

    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    checkOutput("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    checkOutput("cmd_kept_after_clear", {8'd0, cmd}, 32'h00A51234);

    applyStimulus(8'h01, 4, 1'b0);
    applyStimulus(8'h02, 2, 1'b0);
    applyStimulus(8'h03, 2, 1'b0);
    checkOutput("cmd_010203", {8'd0, cmd}, 32'h00010203);

    // Timed-out partial command is discarded
    applyStimulus(8'hFF, 5, 1'b0);
    applyStimulus(8'hEE, 3, 1'b0);
    applyStimulus(8'h0A, 2500, 1'b0);
    applyStimulus(8'h0B, 3, 1'b0);
    applyStimulus(8'h0C, 3, 1'b0);
    checkOutput("cmd_0A0B0C", {8'd0, cmd}, 32'h000A0B0C);

    // Gap exactly at the limit is accepted, one beyond is not
    applyStimulus(8'h5A, 3, 1'b0);
    applyStimulus(8'h6B, TIMEOUT, 1'b0);
    applyStimulus(8'h7C, TIMEOUT, 1'b0);
    checkOutput("cmd_gap_at_limit", {8'd0, cmd}, 32'h005A6B7C);
    applyStimulus(8'h81, 3, 1'b0);
    applyStimulus(8'h92, TIMEOUT + 1, 1'b0);
    applyStimulus(8'hA3, 3, 1'b0);
    applyStimulus(8'hB4, 3, 1'b1);
    checkOutput("cmd_gap_over_limit", {8'd0, cmd}, 32'h0092A3B4);
    checkOutput("set_beats_clear", {31'd0, cmd_rdy}, 32'd1);

    // Response held 3 cycles plus a stray request mid-frame
    sendResp(8'hA5, 3, 1'b1);
    waitTxIdle();

    // Reset after a lone first byte
    applyStimulus(8'h77, 3, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    doReset();
    applyStimulus(8'h11, 3, 1'b0);
    applyStimulus(8'h22, 3, 1'b0);
    applyStimulus(8'h33, 3, 1'b0);
    checkOutput("cmd_after_reset", {8'd0, cmd}, 32'h00112233);

    // Full duplex
    fork
      sendResp(8'h3C, 1, 1'b0);
      begin
        applyStimulus(8'hC0, 3, 1'b0);
        applyStimulus(8'hDE, 4, 1'b0);
        applyStimulus(8'h55, 2, 1'b0);
      end
    join
    waitTxIdle();
    checkOutput("cmd_full_duplex", {8'd0, cmd}, 32'h00C0DE55);

    // Randomized traffic on both paths
    fork
      begin
        for (int i = 0; i < 75; i++) begin
          int r;
          int d;
          r = $urandom_range(0, 15);
          case (r)
            0:       d = TIMEOUT - 1;
            1:       d = TIMEOUT;
            2:       d = TIMEOUT + 1;
            default: d = $urandom_range(2, 12);
          endcase
          applyStimulus(8'($urandom), d, $urandom_range(0, 7) == 0);
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          sendResp(8'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 20)) begin
            @(posedge clk); #1;
          end
        end
      end
    join

    waitTxIdle();
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("cmd_queue_drained", cmdQ.size(), 32'd0);
    checkOutput("trmt_queue_drained", trmtQ.size(), 32'd0);
    checkOutput("clr_rdy_pulse_count", clrCount, bytesSent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
